operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Decode-side reader of the integer register file. Drives the two regfile read addresses and resolves RAW hazards by forwarding from EX/MEM/WB.
- Stalls one instruction on a load-use hazard. Registers the resolved operands into the ID/EX pipeline register under a valid/ready handshake.
- Sits between the decoder and the execute stage; the regfile itself stays purely combinational-read and has no write bypass.

Parameters:
- XLEN, 32, datapath width
- RA_W, 5, register address width
- STALL_CNT_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoder presents an instruction
- in_ready  out  1  block accepts the instruction this cycle
- in_pc  in  XLEN  instruction PC
- in_rs1_addr / in_rs2_addr  in  RA_W each  source registers
- in_rs1_used / in_rs2_used  in  1 each  source is really read (hazard qualifier)
- in_rd_addr  in  RA_W  destination
- in_rd_we  in  1  instruction writes rd
- in_is_load  in  1  instruction is a load
- rf_rs1_addr / rf_rs2_addr  out  RA_W each  regfile read addresses (= in_rs*_addr, combinational)
- rf_rs1_data / rf_rs2_data  in  XLEN each  regfile read data
- ex_rd_addr, ex_we, ex_is_load, ex_data  in  RA_W/1/1/XLEN  EX-stage result
- mem_rd_addr, mem_we, mem_data  in  RA_W/1/XLEN  MEM-stage result (load data valid here)
- wb_rd_addr, wb_we, wb_data  in  RA_W/1/XLEN  WB write (same signals that drive the regfile)
- flush  in  1  branch/exception kill
- out_valid  out  1  ID/EX register holds a valid instruction
- out_ready  in  1  EX accepts
- out_pc, out_rs1_data, out_rs2_data  out  XLEN each
- out_rd_addr  out  RA_W
- out_rd_we, out_is_load  out  1 each
- stall_count  out  STALL_CNT_W  load-use stall cycles, saturating

Behaviour:
- Reset (rst_n=0, async): out_valid=0, all out_* data fields=0, stall_count=0. in_ready is combinational and evaluates to 0 while reset is asserted.
- Forward select per source s, in priority order:
  - addr==0 -> 0
  - ex_we && ex_rd_addr==addr -> ex_data
  - mem_we && match -> mem_data
  - wb_we && match -> wb_data
  - else rf data
- WB forwarding is mandatory because the regfile shows the old value during its write cycle.
- hazard = in_valid && ex_we && ex_is_load && ex_rd_addr!=0 && ((in_rs1_used && rs1 match) || (in_rs2_used && rs2 match)).
- adv = !out_valid || out_ready.
- in_ready = adv && !hazard && !flush, or 1 when flush=1 (the incoming instruction is consumed and discarded).
- On each rising edge, in priority order:
  - flush: out_valid<=0; data fields hold.
  - else if adv && in_valid && !hazard: load all out_* with resolved operands; out_valid<=1.
  - else if adv: out_valid<=0 (bubble, including during a hazard).
  - else (EX stalled): hold everything.
- Latency: one cycle from acceptance to out_valid.
- Throughput: 1/cycle with no hazards. A load-use hazard costs exactly 1 bubble, because the load is in MEM on the next cycle and mem_data forwards.
- stall_count increments by 1 on each cycle with hazard && adv && !flush, and saturates at all-ones.
- rd_addr==0 writes are never forwarded. x0 always reads 0, regardless of rf data.
- Reset mid-stall: the stall is dropped and the counter is cleared.

Decomposition:
- Shared cpu package holds XLEN, RA_W, and a forwarding-source enum (FWD_ZERO, FWD_EX, FWD_MEM, FWD_WB, FWD_RF).
- One natural sub-module: fwd_mux, the combinational per-operand priority select. It is instantiated twice and is the basis for the hazard compare.

Test Plan:
- No hazard: x5=0x11 in rf, issue rs1=5 rs2=0 -> next cycle out_rs1_data=0x11, out_rs2_data=0, out_valid=1.
- Priority: ex_we/ex_rd=3/ex_data=0xAA, mem_rd=3 data 0xBB, wb_rd=3 data 0xCC, rs1=3 -> out_rs1_data=0xAA. Drop EX -> 0xBB. Drop MEM -> 0xCC.
- Load-use: ex_is_load=1, ex_rd=7, incoming rs2=7 -> in_ready=0 for 1 cycle, a bubble is emitted, stall_count=1. Next cycle with mem_rd=7 data 0x1234 -> out_rs2_data=0x1234.
- x0: wb_we=1, wb_rd=0, wb_data=0xFFFF, rs1=0 -> out_rs1_data=0.
- Backpressure/flush: out_ready=0 for 3 cycles -> outputs hold and in_ready=0. Then flush=1 -> out_valid=0 next cycle and the incoming instruction is discarded.
- Async reset asserted mid-stall (no clock edge) -> out_valid=0 and stall_count=0 immediately.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared decode-side types: datapath widths, forwarding source tags and the ID/EX payload.
package operand_fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned RA_W        = 5;
    localparam int unsigned STALL_CNT_W = 16;

    typedef enum logic [2:0] {
        FWD_ZERO,
        FWD_EX,
        FWD_MEM,
        FWD_WB,
        FWD_RF
    } fwd_src_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [RA_W-1:0] rd_addr;
        logic            rd_we;
        logic            is_load;
    } idex_t;

endpackage

// File: rtl/operand_fetch_fwd_mux.sv
// Per-operand forwarding select: x0, then youngest producer (EX, MEM, WB), then regfile.
module operand_fetch_fwd_mux
    import operand_fetch_pkg::*;
(
    input  logic [RA_W-1:0] addr,
    input  logic [XLEN-1:0] rf_data,
    input  logic [RA_W-1:0] ex_rd_addr,
    input  logic            ex_we,
    input  logic [XLEN-1:0] ex_data,
    input  logic [RA_W-1:0] mem_rd_addr,
    input  logic            mem_we,
    input  logic [XLEN-1:0] mem_data,
    input  logic [RA_W-1:0] wb_rd_addr,
    input  logic            wb_we,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data_c,
    output fwd_src_e        src_c
);

    always_comb begin
        src_c  = FWD_RF;
        data_c = rf_data;
        if (addr == '0) begin
            src_c  = FWD_ZERO;
            data_c = '0;
        end else if (ex_we && (ex_rd_addr == addr)) begin
            src_c  = FWD_EX;
            data_c = ex_data;
        end else if (mem_we && (mem_rd_addr == addr)) begin
            src_c  = FWD_MEM;
            data_c = mem_data;
        end else if (wb_we && (wb_rd_addr == addr)) begin
            // The regfile still shows the old value during its write cycle.
            src_c  = FWD_WB;
            data_c = wb_data;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: regfile read, EX/MEM/WB forwarding, load-use stall and the ID/EX register.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [RA_W-1:0]        in_rs1_addr,
    input  logic [RA_W-1:0]        in_rs2_addr,
    input  logic                   in_rs1_used,
    input  logic                   in_rs2_used,
    input  logic [RA_W-1:0]        in_rd_addr,
    input  logic                   in_rd_we,
    input  logic                   in_is_load,
    output logic [RA_W-1:0]        rf_rs1_addr,
    output logic [RA_W-1:0]        rf_rs2_addr,
    input  logic [XLEN-1:0]        rf_rs1_data,
    input  logic [XLEN-1:0]        rf_rs2_data,
    input  logic [RA_W-1:0]        ex_rd_addr,
    input  logic                   ex_we,
    input  logic                   ex_is_load,
    input  logic [XLEN-1:0]        ex_data,
    input  logic [RA_W-1:0]        mem_rd_addr,
    input  logic                   mem_we,
    input  logic [XLEN-1:0]        mem_data,
    input  logic [RA_W-1:0]        wb_rd_addr,
    input  logic                   wb_we,
    input  logic [XLEN-1:0]        wb_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_rs1_data,
    output logic [XLEN-1:0]        out_rs2_data,
    output logic [RA_W-1:0]        out_rd_addr,
    output logic                   out_rd_we,
    output logic                   out_is_load,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic [XLEN-1:0]        rs1_fwd, rs2_fwd;
    fwd_src_e               rs1_src, rs2_src;
    logic                   hazard_c, adv_c;
    logic                   out_valid_q, out_valid_d;
    idex_t                  payload_q, payload_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign rf_rs1_addr = in_rs1_addr;
    assign rf_rs2_addr = in_rs2_addr;

    operand_fetch_fwd_mux u_rs1_fwd (
        .addr        (in_rs1_addr),
        .rf_data     (rf_rs1_data),
        .ex_rd_addr  (ex_rd_addr),
        .ex_we       (ex_we),
        .ex_data     (ex_data),
        .mem_rd_addr (mem_rd_addr),
        .mem_we      (mem_we),
        .mem_data    (mem_data),
        .wb_rd_addr  (wb_rd_addr),
        .wb_we       (wb_we),
        .wb_data     (wb_data),
        .data_c      (rs1_fwd),
        .src_c       (rs1_src)
    );

    operand_fetch_fwd_mux u_rs2_fwd (
        .addr        (in_rs2_addr),
        .rf_data     (rf_rs2_data),
        .ex_rd_addr  (ex_rd_addr),
        .ex_we       (ex_we),
        .ex_data     (ex_data),
        .mem_rd_addr (mem_rd_addr),
        .mem_we      (mem_we),
        .mem_data    (mem_data),
        .wb_rd_addr  (wb_rd_addr),
        .wb_we       (wb_we),
        .wb_data     (wb_data),
        .data_c      (rs2_fwd),
        .src_c       (rs2_src)
    );

    // An EX-sourced operand from a load is not ready yet; FWD_EX already excludes x0.
    assign hazard_c = in_valid && ex_is_load &&
                      ((in_rs1_used && (rs1_src == FWD_EX)) ||
                       (in_rs2_used && (rs2_src == FWD_EX)));
    assign adv_c    = !out_valid_q || out_ready;
    assign in_ready = rst_n && (flush || (adv_c && !hazard_c));

    always_comb begin
        out_valid_d = out_valid_q;
        payload_d   = payload_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (adv_c && in_valid && !hazard_c) begin
            out_valid_d        = 1'b1;
            payload_d.pc       = in_pc;
            payload_d.rs1_data = rs1_fwd;
            payload_d.rs2_data = rs2_fwd;
            payload_d.rd_addr  = in_rd_addr;
            payload_d.rd_we    = in_rd_we;
            payload_d.is_load  = in_is_load;
        end else if (adv_c) begin
            out_valid_d = 1'b0;
        end
        if (hazard_c && adv_c && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            payload_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            payload_q   <= payload_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = payload_q.pc;
    assign out_rs1_data = payload_q.rs1_data;
    assign out_rs2_data = payload_q.rs2_data;
    assign out_rd_addr  = payload_q.rd_addr;
    assign out_rd_we    = payload_q.rd_we;
    assign out_is_load  = payload_q.is_load;
    assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed scenarios plus randomized traffic vs a reference model.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid, in_ready;
    logic [XLEN-1:0]        in_pc;
    logic [RA_W-1:0]        in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic                   in_rs1_used, in_rs2_used, in_rd_we, in_is_load;
    logic [RA_W-1:0]        rf_rs1_addr, rf_rs2_addr;
    logic [XLEN-1:0]        rf_rs1_data, rf_rs2_data;
    logic [RA_W-1:0]        ex_rd_addr, mem_rd_addr, wb_rd_addr;
    logic                   ex_we, ex_is_load, mem_we, wb_we;
    logic [XLEN-1:0]        ex_data, mem_data, wb_data;
    logic                   flush;
    logic                   out_valid, out_ready;
    logic [XLEN-1:0]        out_pc, out_rs1_data, out_rs2_data;
    logic [RA_W-1:0]        out_rd_addr;
    logic                   out_rd_we, out_is_load;
    logic [STALL_CNT_W-1:0] stall_count;

    int    n_tests = 0;
    int    n_fail  = 0;
    idex_t exp_q[$];
    idex_t mon_e;
    logic  mv = 1'b0;
    int    mcnt = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
        .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we), .in_is_load(in_is_load),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .ex_rd_addr(ex_rd_addr), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_data(ex_data),
        .mem_rd_addr(mem_rd_addr), .mem_we(mem_we), .mem_data(mem_data),
        .wb_rd_addr(wb_rd_addr), .wb_we(wb_we), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we), .out_is_load(out_is_load),
        .stall_count(stall_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference operand value: x0, then newest writer wins, else regfile.
    function automatic logic [XLEN-1:0] ref_fwd(input logic [RA_W-1:0] a, input logic [XLEN-1:0] rf);
        if (a == 0)                        return '0;
        if (ex_we  && ex_rd_addr  == a)    return ex_data;
        if (mem_we && mem_rd_addr == a)    return mem_data;
        if (wb_we  && wb_rd_addr  == a)    return wb_data;
        return rf;
    endfunction

    function automatic logic ref_hazard();
        return in_valid && ex_we && ex_is_load && (ex_rd_addr != 0) &&
               ((in_rs1_used && ex_rd_addr == in_rs1_addr) ||
                (in_rs2_used && ex_rd_addr == in_rs2_addr));
    endfunction

    // Called one time unit after a rising edge with inputs already set; returns the same way.
    task automatic drive_cycle();
        logic  h, a;
        idex_t e;
        #1;
        h = ref_hazard();
        a = !mv || out_ready;
        check("in_ready", 64'(in_ready), 64'(flush || (a && !h)));
        check("rf_rs1_addr", 64'(rf_rs1_addr), 64'(in_rs1_addr));
        e.pc       = in_pc;
        e.rs1_data = ref_fwd(in_rs1_addr, rf_rs1_data);
        e.rs2_data = ref_fwd(in_rs2_addr, rf_rs2_data);
        e.rd_addr  = in_rd_addr;
        e.rd_we    = in_rd_we;
        e.is_load  = in_is_load;
        @(posedge clk);
        if (h && a && !flush && mcnt < 65535) mcnt++;
        if (flush) begin
            if (mv && !out_ready) void'(exp_q.pop_back());
            mv = 1'b0;
        end else if (a && in_valid && !h) begin
            exp_q.push_back(e);
            mv = 1'b1;
        end else if (a) begin
            mv = 1'b0;
        end
        #1;
        check("out_valid", 64'(out_valid), 64'(mv));
        check("stall_count", 64'(stall_count), 64'(mcnt));
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_pc = '0; in_rs1_addr = '0; in_rs2_addr = '0;
        in_rs1_used = 0; in_rs2_used = 0; in_rd_addr = '0; in_rd_we = 0; in_is_load = 0;
        rf_rs1_data = '0; rf_rs2_data = '0;
        ex_rd_addr = '0; ex_we = 0; ex_is_load = 0; ex_data = '0;
        mem_rd_addr = '0; mem_we = 0; mem_data = '0;
        wb_rd_addr = '0; wb_we = 0; wb_data = '0;
        flush = 0; out_ready = 1;
    endtask

    task automatic issue(input logic [XLEN-1:0] pc, input logic [RA_W-1:0] r1, input logic [RA_W-1:0] r2);
        in_valid = 1; in_pc = pc; in_rs1_addr = r1; in_rs2_addr = r2;
        in_rs1_used = 1; in_rs2_used = 1; in_rd_addr = 5'd9; in_rd_we = 1; in_is_load = 0;
    endtask

    // Scoreboard monitor: every handshake on the output pops one expected payload.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got pc 0x%0h expected no transfer", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out_pc, out_rs1_data, out_rs2_data, out_rd_addr, out_rd_we, out_is_load} !== mon_e) begin
                    n_fail++;
                    $display("FAIL sb_payload: got pc=%0h rs1=%0h rs2=%0h rd=%0d we=%0b ld=%0b expected pc=%0h rs1=%0h rs2=%0h rd=%0d we=%0b ld=%0b",
                             out_pc, out_rs1_data, out_rs2_data, out_rd_addr, out_rd_we, out_is_load,
                             mon_e.pc, mon_e.rs1_data, mon_e.rs2_data, mon_e.rd_addr, mon_e.rd_we, mon_e.is_load);
                end
            end
        end
    end

    initial begin
        idle_inputs();
        rst_n = 0;
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_rs1_data", 64'(out_rs1_data), 64'd0);
        check("rst_stall_count", 64'(stall_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        #10 rst_n = 1;
        @(posedge clk); #1;

        // No hazard: x5 from regfile, rs2 = x0.
        issue(32'h100, 5'd5, 5'd0); rf_rs1_data = 32'h11; rf_rs2_data = 32'h77;
        drive_cycle();
        check("nohaz_rs1", 64'(out_rs1_data), 64'h11);
        check("nohaz_rs2", 64'(out_rs2_data), 64'h0);

        // Forwarding priority EX > MEM > WB.
        issue(32'h104, 5'd3, 5'd0); rf_rs1_data = 32'hDD;
        ex_we = 1; ex_rd_addr = 5'd3; ex_data = 32'hAA;
        mem_we = 1; mem_rd_addr = 5'd3; mem_data = 32'hBB;
        wb_we = 1; wb_rd_addr = 5'd3; wb_data = 32'hCC;
        drive_cycle();
        check("prio_ex", 64'(out_rs1_data), 64'hAA);
        in_pc = 32'h108; ex_we = 0;
        drive_cycle();
        check("prio_mem", 64'(out_rs1_data), 64'hBB);
        in_pc = 32'h10C; mem_we = 0;
        drive_cycle();
        check("prio_wb", 64'(out_rs1_data), 64'hCC);

        // Load-use on rs2: one bubble, then MEM forwards the load data.
        idle_inputs();
        issue(32'h200, 5'd0, 5'd7);
        ex_we = 1; ex_is_load = 1; ex_rd_addr = 5'd7; ex_data = 32'hDEAD;
        drive_cycle();
        check("lu_bubble", 64'(out_valid), 64'd0);
        check("lu_stall", 64'(stall_count), 64'd1);
        ex_we = 0; ex_is_load = 0; mem_we = 1; mem_rd_addr = 5'd7; mem_data = 32'h1234;
        drive_cycle();
        check("lu_fwd_mem", 64'(out_rs2_data), 64'h1234);

        // x0 is never forwarded.
        idle_inputs();
        issue(32'h300, 5'd0, 5'd0); wb_we = 1; wb_rd_addr = 5'd0; wb_data = 32'hFFFF; rf_rs1_data = 32'h55;
        drive_cycle();
        check("x0_rs1", 64'(out_rs1_data), 64'd0);

        // Backpressure for three cycles, then flush discards the held and incoming instruction.
        idle_inputs();
        issue(32'h400, 5'd1, 5'd2); rf_rs1_data = 32'h4001;
        drive_cycle();
        out_ready = 0; in_pc = 32'h404;
        for (int i = 0; i < 3; i++) begin
            drive_cycle();
            check("bp_hold_pc", 64'(out_pc), 64'h400);
        end
        flush = 1;
        drive_cycle();
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_hold_pc", 64'(out_pc), 64'h400);
        idle_inputs();

        // Randomized traffic with small register range to provoke forwarding and hazards.
        for (int c = 0; c < 600; c++) begin
            in_valid    = ($urandom % 5) != 0;
            in_pc       = $urandom;
            in_rs1_addr = RA_W'($urandom % 8);
            in_rs2_addr = RA_W'($urandom % 8);
            in_rs1_used = ($urandom % 4) != 0;
            in_rs2_used = ($urandom % 4) != 0;
            in_rd_addr  = RA_W'($urandom % 32);
            in_rd_we    = 1'($urandom);
            in_is_load  = 1'($urandom);
            rf_rs1_data = $urandom; rf_rs2_data = $urandom;
            ex_we  = 1'($urandom); ex_is_load = 1'($urandom); ex_rd_addr = RA_W'($urandom % 8); ex_data = $urandom;
            mem_we = 1'($urandom); mem_rd_addr = RA_W'($urandom % 8); mem_data = $urandom;
            wb_we  = 1'($urandom); wb_rd_addr = RA_W'($urandom % 8); wb_data = $urandom;
            flush     = ($urandom % 16) == 0;
            out_ready = ($urandom % 4) != 0;
            drive_cycle();
        end

        idle_inputs();
        drive_cycle();
        drive_cycle();
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        // Async reset in the middle of a load-use stall.
        issue(32'h500, 5'd6, 5'd0);
        ex_we = 1; ex_is_load = 1; ex_rd_addr = 5'd6;
        drive_cycle();
        #2 rst_n = 0;
        #1;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_stall", 64'(stall_count), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd0);
        mv = 1'b0; mcnt = 0; exp_q.delete();
        idle_inputs();
        #2 rst_n = 1;
        @(posedge clk); #1;
        issue(32'h600, 5'd4, 5'd0); rf_rs1_data = 32'h600D;
        drive_cycle();
        idle_inputs();
        drive_cycle();
        check("post_rst_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
